// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared state encodings, operation codes and default width for
//               the iterative MULT/DIV sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DZ   = 2'd3
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

endpackage

`default_nettype wire

// File: rtl/mdu_step.sv
// ============================================================================
// Module      : mdu_step
// Description : One combinational iteration: shift-add multiply step or
//               restoring shift-subtract divide step on unsigned magnitudes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_step
  import ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_sum    = {1'b0, acc} + {1'b0, m};
    w_rem    = {acc, q[WIDTH-1]};
    w_diff   = w_rem - {1'b0, m};
    acc_next = acc;
    q_next   = q;
    if (mode == OP_MUL) begin
      // {acc,q} is the partial product; the carry of the add shifts into acc
      if (q[0]) begin
        {acc_next, q_next} = {w_sum, q[WIDTH-1:1]};
      end else begin
        {acc_next, q_next} = {1'b0, acc, q[WIDTH-1:1]};
      end
    end else begin
      // remainder stays below the divisor, so bit WIDTH of w_diff is the borrow
      if (!w_diff[WIDTH]) begin
        acc_next = w_diff[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = w_rem[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_div_seq.sv
// ============================================================================
// Module      : mult_div_seq
// Description : Iterative signed MULT/DIV engine and sequencer writing HI/LO,
//               with a one-cycle Done pulse and divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_seq
  import ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MultCtrl,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  op_e              r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic             r_sign_res;
  logic             r_sign_a;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_divzero;

  logic             w_start_mul;
  logic             w_start_div;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  // magnitudes are WIDTH bits wide, so the most negative value maps onto itself
  assign w_abs_a = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign w_abs_b = B[WIDTH-1] ? (~B + 1'b1) : B;

  mdu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mode     (r_op),
    .acc      (r_acc),
    .q        (r_q),
    .m        (r_m),
    .acc_next (w_acc_nxt),
    .q_next   (w_q_nxt)
  );

  always_comb begin
    w_prod = {r_acc, r_q};
    if (r_sign_res) w_prod = ~w_prod + 1'b1;
    w_quot = r_sign_res ? (~r_q + 1'b1) : r_q;
    w_rem  = r_sign_a   ? (~r_acc + 1'b1) : r_acc;
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_mul = 1'b0;
    w_start_div = 1'b0;
    Busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (MultCtrl) begin
          w_start_mul = 1'b1;
          w_state_nxt = ST_RUN;
        end else if (DivCtrl) begin
          if (B != '0) begin
            w_start_div = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_DZ;
          end
        end
      end
      ST_RUN: begin
        Busy = 1'b1;
        if (r_cnt == C_LAST) w_state_nxt = ST_FIX;
      end
      ST_FIX: begin
        Busy        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_DZ: begin
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_op       <= OP_MUL;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_q        <= '0;
      r_m        <= '0;
      r_sign_res <= 1'b0;
      r_sign_a   <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_divzero  <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_mul || w_start_div) begin
            // multiply iterates over |B| with |A| as addend; divide shifts |A| out against |B|
            r_op       <= w_start_mul ? OP_MUL : OP_DIV;
            r_acc      <= '0;
            r_q        <= w_start_mul ? w_abs_b : w_abs_a;
            r_m        <= w_start_mul ? w_abs_a : w_abs_b;
            r_sign_res <= A[WIDTH-1] ^ B[WIDTH-1];
            r_sign_a   <= A[WIDTH-1];
            r_cnt      <= '0;
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        ST_FIX: begin
          if (r_op == OP_MUL) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end
          r_done <= 1'b1;
        end
        ST_DZ: begin
          r_done    <= 1'b1;
          r_divzero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign HI      = r_hi;
  assign LO      = r_lo;
  assign Done    = r_done;
  assign DivZero = r_divzero;

endmodule

`default_nettype wire
